// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters advanced by a pixel enable,
// with a registered decode of sync, active-video, coordinates and wrap ticks.
module vga_sync_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CNT_W    = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pix_en_i,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             video_on_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             line_tick_o,
  output logic             frame_tick_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic sync_level(input logic active);
    return active ? SYNC_POL : ~SYNC_POL;
  endfunction

  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             h_wrap, v_wrap;

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic [CNT_W-1:0] x_q, y_q;
  logic             line_tick_q, line_tick_d;
  logic             frame_tick_q, frame_tick_d;

  // Wrap on >= so a corrupted counter recovers instead of running to 2^CNT_W.
  always_comb begin
    h_wrap = (h_q >= H_LAST);
    v_wrap = (v_q >= V_LAST);
    h_d    = h_q;
    v_d    = v_q;
    if (pix_en_i) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_comb begin
    hsync_d      = sync_level((h_q >= HS_START) && (h_q < HS_END));
    vsync_d      = sync_level((v_q >= VS_START) && (v_q < VS_END));
    video_on_d   = (h_q < H_VIS) && (v_q < V_VIS);
    line_tick_d  = pix_en_i && h_wrap;
    frame_tick_d = pix_en_i && h_wrap && v_wrap;
  end

  // Decode registers sample the counters every clk_i, so all outputs share one cycle of latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q          <= '0;
      v_q          <= '0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      video_on_q   <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      x_q          <= h_q;
      y_q          <= v_q;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign hsync_o      = hsync_q;
  assign vsync_o      = vsync_q;
  assign video_on_o   = video_on_q;
  assign x_o          = x_q;
  assign y_o          = y_q;
  assign line_tick_o  = line_tick_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 instance for line timing, plus a tiny
// active-high-sync instance so whole frames fit in a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;

  logic       hs, vs, von, lt, ft;
  logic [9:0] x, y;
  logic       hs_s, vs_s, von_s, lt_s, ft_s;
  logic [9:0] x_s, y_s;

  always #10 clk = ~clk;

  vga_sync_gen dut (
    .clk_i(clk), .rst_ni(rst_n), .pix_en_i(pix_en),
    .hsync_o(hs), .vsync_o(vs), .video_on_o(von),
    .x_o(x), .y_o(y), .line_tick_o(lt), .frame_tick_o(ft)
  );

  // 16 x 8 raster: H 8+2+3+3, V 4+1+2+1, sync asserted high.
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .CNT_W(10)
  ) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .pix_en_i(pix_en),
    .hsync_o(hs_s), .vsync_o(vs_s), .video_on_o(von_s),
    .x_o(x_s), .y_o(y_s), .line_tick_o(lt_s), .frame_tick_o(ft_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    pix_en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // n = clk edges with pix_en=1 since reset release; outputs show counter after n-1 edges.
  typedef struct {
    int n; int x; int y; bit hs; bit vs; bit von; bit lt; bit ft;
  } vec_t;
  vec_t tbl[13];

  task automatic run_table(input string tag);
    int cur = 0;
    for (int i = 0; i < 13; i++) begin
      while (cur < tbl[i].n) begin
        pix_en = 1'b1;
        step();
        cur++;
      end
      chk($sformatf("%s[%0d].x", tag, i),   x,   tbl[i].x);
      chk($sformatf("%s[%0d].y", tag, i),   y,   tbl[i].y);
      chk($sformatf("%s[%0d].hs", tag, i),  hs,  tbl[i].hs);
      chk($sformatf("%s[%0d].vs", tag, i),  vs,  tbl[i].vs);
      chk($sformatf("%s[%0d].von", tag, i), von, tbl[i].von);
      chk($sformatf("%s[%0d].lt", tag, i),  lt,  tbl[i].lt);
      chk($sformatf("%s[%0d].ft", tag, i),  ft,  tbl[i].ft);
    end
  endtask

  initial begin
    int hs_low, von_cnt, lt_cnt, ft_cnt, bad, runlen, first_fall_x, found, k_found;
    int t[$];
    logic prev_hs, prev_lt, prev_vs, seen;
    logic [9:0] prev_x;

    //            n    x    y  hs vs von lt ft
    tbl[0]  = '{   1,   0, 0, 1, 1, 1, 0, 0};
    tbl[1]  = '{   2,   1, 0, 1, 1, 1, 0, 0};
    tbl[2]  = '{ 640, 639, 0, 1, 1, 1, 0, 0};
    tbl[3]  = '{ 641, 640, 0, 1, 1, 0, 0, 0};
    tbl[4]  = '{ 656, 655, 0, 1, 1, 0, 0, 0};
    tbl[5]  = '{ 657, 656, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{ 752, 751, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{ 753, 752, 0, 1, 1, 0, 0, 0};
    tbl[8]  = '{ 800, 799, 0, 1, 1, 0, 1, 0};
    tbl[9]  = '{ 801,   0, 1, 1, 1, 1, 0, 0};
    tbl[10] = '{1457, 656, 1, 0, 1, 0, 0, 0};
    tbl[11] = '{1600, 799, 1, 1, 1, 0, 1, 0};
    tbl[12] = '{1601,   0, 2, 1, 1, 1, 0, 0};

    // Reset state, held with pix_en active
    rst_n  = 1'b0;
    pix_en = 1'b1;
    step();
    step();
    chk("rst.hs", hs, 1);
    chk("rst.vs", vs, 1);
    chk("rst.von", von, 0);
    chk("rst.x", x, 0);
    chk("rst.y", y, 0);
    chk("rst.lt", lt, 0);
    chk("rst.ft", ft, 0);
    chk("rst.hs_s", hs_s, 0);
    chk("rst.vs_s", vs_s, 0);
    rst_n = 1'b1;

    run_table("init");

    // Two full lines (1..2) with continuous enable
    hs_low = 0; von_cnt = 0; lt_cnt = 0; first_fall_x = -1;
    prev_hs = hs;
    t.delete();
    for (int k = 0; k < 1600; k++) begin
      pix_en = 1'b1;
      step();
      if (!hs) hs_low++;
      if (von) von_cnt++;
      if (lt) t.push_back(k);
      if (prev_hs && !hs && first_fall_x < 0) first_fall_x = int'(x);
      prev_hs = hs;
    end
    chk("line.hs_low", hs_low, 192);
    chk("line.von", von_cnt, 1280);
    chk("line.lt_cnt", t.size(), 2);
    chk("line.lt_period", (t.size() == 2) ? t[1] - t[0] : 0, 800);
    chk("line.hs_start_x", first_fall_x, 656);

    // Pause at counter (300,1): one idle edge lets x_o catch up, then everything freezes
    do_reset();
    for (int k = 0; k < 1100; k++) begin
      pix_en = 1'b1;
      step();
    end
    chk("pause.x_pre", x, 299);
    pix_en = 1'b0;
    step();
    chk("pause.x", x, 300);
    chk("pause.y", y, 1);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (x !== 10'd300 || y !== 10'd1 || hs !== 1'b1 || vs !== 1'b1 ||
          von !== 1'b1 || lt !== 1'b0 || ft !== 1'b0) bad++;
    end
    chk("pause.frozen_bad", bad, 0);
    pix_en = 1'b1;
    step();
    chk("resume.x0", x, 300);
    step();
    chk("resume.x1", x, 301);

    // Divider mode: enable every other clk
    do_reset();
    prev_hs = 1'b1; prev_lt = 1'b0; prev_x = x; seen = 1'b0;
    runlen = 1; bad = 0; lt_cnt = 0; hs_low = 0; first_fall_x = -1;
    t.delete();
    for (int k = 0; k < 4000; k++) begin
      pix_en = (k % 2 == 0);
      step();
      if (x !== prev_x) begin
        if (seen && runlen != 2) bad++;
        seen = 1'b1;
        runlen = 1;
      end else begin
        runlen++;
      end
      prev_x = x;
      if (lt && prev_lt) bad++;
      if (lt) lt_cnt++;
      prev_lt = lt;
      if (prev_hs && !hs) begin
        t.push_back(k);
        if (first_fall_x < 0) first_fall_x = int'(x);
      end
      if (!hs && t.size() == 1) hs_low++;
      prev_hs = hs;
    end
    chk("div.hold_and_tick_bad", bad, 0);
    chk("div.lt_cnt", lt_cnt, 2);
    chk("div.hs_falls", t.size(), 2);
    chk("div.hs_period", (t.size() >= 2) ? t[1] - t[0] : 0, 1600);
    chk("div.hs_low", hs_low, 192);
    chk("div.hs_start_x", first_fall_x, 656);

    // Asynchronous reset inside hsync
    found = 0;
    for (int k = 0; k < 2000 && found == 0; k++) begin
      pix_en = 1'b1;
      step();
      if (x == 10'd700) found = 1;
    end
    chk("mid.reached_700", found, 1);
    chk("mid.hs_before", hs, 0);
    rst_n = 1'b0;
    #2;
    chk("mid.hs", hs, 1);
    chk("mid.vs", vs, 1);
    chk("mid.x", x, 0);
    chk("mid.y", y, 0);
    chk("mid.von", von, 0);
    chk("mid.lt", lt, 0);
    chk("mid.hs_s", hs_s, 0);
    step();
    rst_n = 1'b1;
    run_table("post");

    // Whole frames on the 16x8 instance (frame = 128 clk)
    do_reset();
    prev_vs = 1'b0; runlen = 0; bad = 0; ft_cnt = 0; found = 0; k_found = -1;
    t.delete();
    for (int k = 0; k < 400; k++) begin
      pix_en = 1'b1;
      step();
      if (vs_s && !prev_vs && found == 0) begin
        found = 1;
        chk("frm.vs_start_y", y_s, 5);
        chk("frm.vs_start_x", x_s, 0);
      end
      if (vs_s && found == 1) runlen++;
      if (!vs_s && prev_vs) found = 2;
      prev_vs = vs_s;
      if (ft_s) begin
        t.push_back(k);
        if (!lt_s || x_s !== 10'd15 || y_s !== 10'd7) bad++;
      end
      if (t.size() == 1 && k == t[0] + 1) k_found = int'(y_s);
    end
    chk("frm.vs_len", runlen, 32);
    chk("frm.ft_cnt", t.size(), 3);
    chk("frm.ft_first", (t.size() > 0) ? t[0] : -1, 127);
    chk("frm.ft_period", (t.size() >= 2) ? t[1] - t[0] : 0, 128);
    chk("frm.ft_align_bad", bad, 0);
    chk("frm.y_after_wrap", k_found, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
